// File: rtl/regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_write_arbiter
//  Purpose  : Round-robin arbiter that shares the single write port of a
//             NUM x BITS enable-gated register bank among REQ requesters.
//             Arbitration is combinational; the bank-facing write stage is
//             registered (one cycle latency, one write per cycle sustained).
//  Ports    : clk, reset_n    - clock, synchronous active-low reset
//             hold            - suppresses any grant this cycle
//             req_valid/addr/data - flattened per-requester write requests
//             req_ready       - one-hot (or zero) combinational grant
//             wr_en/wr_data   - registered one-hot enable and data to bank
//             wr_valid/wr_err - registered accept / bad-address strobes
//             grant_id        - requester owning the current output stage
//             wr_count        - saturating count of accepted writes
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_write_arbiter #(
  parameter int BITS   = 32,
  parameter int NUM    = 7,
  parameter int REQ    = 4,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hold,
  input  logic [REQ-1:0]         req_valid,
  input  logic [REQ*ADDR_W-1:0]  req_addr,
  input  logic [REQ*BITS-1:0]    req_data,
  output logic [REQ-1:0]         req_ready,
  output logic [NUM-1:0]         wr_en,
  output logic [BITS-1:0]        wr_data,
  output logic                   wr_valid,
  output logic                   wr_err,
  output logic [$clog2(REQ)-1:0] grant_id,
  output logic [15:0]            wr_count
);

  localparam int              PTR_W     = $clog2(REQ);
  localparam logic [15:0]     COUNT_MAX = 16'hFFFF;
  localparam logic [NUM-1:0]  EN_ONE    = NUM'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(REQ - 1);

  // --------------------------------------------------------------------------
  // Per-requester views of the flattened request buses
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_arr [REQ];
  logic [BITS-1:0]   data_arr [REQ];

  for (genvar g = 0; g < REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*BITS +: BITS];
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [NUM-1:0]   wr_en_q,    wr_en_d;
  logic [BITS-1:0]  wr_data_q,  wr_data_d;
  logic             wr_valid_q, wr_valid_d;
  logic             wr_err_q,   wr_err_d;
  logic [PTR_W-1:0] grant_id_q, grant_id_d;
  logic [15:0]      wr_count_q, wr_count_d;

  // --------------------------------------------------------------------------
  // Round-robin arbitration
  // --------------------------------------------------------------------------
  logic [REQ-1:0]    eligible;
  logic [REQ-1:0]    grant_vec;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand_idx;
  int                cand;
  logic              xfer;

  always_comb begin
    eligible  = (reset_n && !hold) ? req_valid : '0;
    grant_vec = '0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    // Walk offsets from farthest to nearest so the eligible requester
    // closest to rr_ptr is the last one written and therefore wins.
    for (int k = REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= REQ) begin
        cand = cand - REQ;
      end
      cand_idx = PTR_W'(cand);
      if (eligible[cand_idx]) begin
        grant_vec           = '0;
        grant_vec[cand_idx] = 1'b1;
        grant_idx           = cand_idx;
      end
    end
  end

  // A grant is only ever issued to a valid requester, so any grant is a transfer.
  assign xfer = |grant_vec;

  // --------------------------------------------------------------------------
  // Next-state for pointer and output stage
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] sel_addr;
  logic              addr_ok;

  assign sel_addr = addr_arr[grant_idx];
  assign addr_ok  = ({{(32-ADDR_W){1'b0}}, sel_addr} < NUM);

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_en_d    = '0;
    wr_err_d   = 1'b0;
    wr_valid_d = xfer;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    wr_count_d = wr_count_q;
    if (xfer) begin
      rr_ptr_d   = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
      wr_data_d  = data_arr[grant_idx];
      grant_id_d = grant_idx;
      // Out-of-range addresses are still accepted and counted, but must
      // never touch the bank.
      wr_en_d    = addr_ok ? (EN_ONE << sel_addr) : '0;
      wr_err_d   = !addr_ok;
      if (wr_count_q != COUNT_MAX) begin
        wr_count_d = wr_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      grant_id_q <= '0;
      wr_count_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      wr_err_q   <= wr_err_d;
      grant_id_q <= grant_id_d;
      wr_count_q <= wr_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready = grant_vec;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign wr_valid  = wr_valid_q;
  assign wr_err    = wr_err_q;
  assign grant_id  = grant_id_q;
  assign wr_count  = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_write_arbiter
//  Purpose  : Self-checking bench for regbank_write_arbiter (REQ=4, NUM=7,
//             BITS=32, ADDR_W=3). Vector table gives inputs and the expected
//             grant; the expected output stage is queued and compared one
//             cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_write_arbiter;

  localparam int BITS   = 32;
  localparam int NUM    = 7;
  localparam int REQ    = 4;
  localparam int ADDR_W = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                hold;
  logic [REQ-1:0]      req_valid;
  logic [REQ*ADDR_W-1:0] req_addr;
  logic [REQ*BITS-1:0] req_data;
  logic [REQ-1:0]      req_ready;
  logic [NUM-1:0]      wr_en;
  logic [BITS-1:0]     wr_data;
  logic                wr_valid;
  logic                wr_err;
  logic [1:0]          grant_id;
  logic [15:0]         wr_count;

  regbank_write_arbiter #(
    .BITS(BITS), .NUM(NUM), .REQ(REQ), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_err(wr_err), .grant_id(grant_id),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        h;
    logic [3:0]  v;
    logic [11:0] a;     // octal digit i = address of requester i
    logic [31:0] seed;  // requester i data = seed + i
    logic [3:0]  rdy;   // expected req_ready
  } vec_t;

  typedef struct {
    logic        v;
    logic [6:0]  en;
    logic        err;
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  vec_t  tbl [21];
  exp_t  sb [$];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cnt_model = '0;
  logic [1:0]  last_id   = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at posedge+1: drive inputs, check the grant, queue the expected
  // output stage, advance one edge and compare.
  task automatic step(input logic h, input logic [3:0] v, input logic [11:0] a,
                      input logic [31:0] seed, input logic [3:0] rdy);
    exp_t        e;
    int          gi;
    logic [2:0]  ga;
    hold      = h;
    req_valid = v;
    req_addr  = a;
    for (int i = 0; i < REQ; i++) req_data[i*BITS +: BITS] = seed + 32'(i);
    #1;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("onehot0_ready", 32'($onehot0(req_ready)), 32'd1);
    e.v = (rdy != 4'b0000);
    if (e.v) begin
      gi = 0;
      for (int i = 0; i < REQ; i++) if (rdy[i]) gi = i;
      ga     = a[gi*3 +: 3];
      e.err  = (ga >= 3'(NUM));
      e.en   = e.err ? 7'b0 : (7'b1 << ga);
      e.id   = 2'(gi);
      e.data = seed + 32'(gi);
      last_id   = e.id;
      last_data = e.data;
      if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    end else begin
      e.en   = '0;
      e.err  = 1'b0;
      e.id   = last_id;
      e.data = last_data;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("wr_valid", 32'(wr_valid), 32'(e.v));
      chk("wr_en", 32'(wr_en), 32'(e.en));
      chk("wr_err", 32'(wr_err), 32'(e.err));
      chk("grant_id", 32'(grant_id), 32'(e.id));
      chk("wr_data", wr_data, e.data);
      chk("wr_count", 32'(wr_count), 32'(cnt_model));
      chk("onehot0_wr_en", 32'($onehot0(wr_en)), 32'd1);
      chk("en_implies_valid", 32'((wr_en == '0) || wr_valid), 32'd1);
      chk("err_implies_no_en", 32'(!wr_err || (wr_en == '0)), 32'd1);
    end
  endtask

  initial begin
    //           h     valid    addr      seed           ready
    tbl[0]  = '{1'b0, 4'b1111, 12'o3210, 32'h1000_0000, 4'b0001};
    tbl[1]  = '{1'b0, 4'b1111, 12'o3210, 32'h1100_0000, 4'b0010};
    tbl[2]  = '{1'b0, 4'b1111, 12'o6543, 32'h1200_0000, 4'b0100};
    tbl[3]  = '{1'b0, 4'b1111, 12'o6543, 32'h1300_0000, 4'b1000};
    tbl[4]  = '{1'b0, 4'b1111, 12'o2222, 32'h1400_0000, 4'b0001};
    tbl[5]  = '{1'b0, 4'b1111, 12'o4444, 32'h1500_0000, 4'b0010};
    tbl[6]  = '{1'b0, 4'b1111, 12'o1111, 32'h1600_0000, 4'b0100};
    tbl[7]  = '{1'b0, 4'b1111, 12'o1111, 32'h1700_0000, 4'b1000};
    tbl[8]  = '{1'b0, 4'b0100, 12'o0500, 32'hDEAD_BEED, 4'b0100};
    tbl[9]  = '{1'b0, 4'b1001, 12'o0000, 32'h2000_0000, 4'b1000};
    tbl[10] = '{1'b0, 4'b1001, 12'o0000, 32'h2100_0000, 4'b0001};
    tbl[11] = '{1'b0, 4'b0100, 12'o0300, 32'h2200_0000, 4'b0100};
    tbl[12] = '{1'b0, 4'b0010, 12'o0030, 32'h2300_0000, 4'b0010};
    tbl[13] = '{1'b0, 4'b0010, 12'o0070, 32'h2400_0000, 4'b0010};
    tbl[14] = '{1'b1, 4'b1111, 12'o1111, 32'h2500_0000, 4'b0000};
    tbl[15] = '{1'b1, 4'b1111, 12'o1111, 32'h2500_0000, 4'b0000};
    tbl[16] = '{1'b1, 4'b1111, 12'o1111, 32'h2500_0000, 4'b0000};
    tbl[17] = '{1'b0, 4'b1111, 12'o1234, 32'h2600_0000, 4'b0100};
    tbl[18] = '{1'b0, 4'b0000, 12'o0000, 32'h2700_0000, 4'b0000};
    tbl[19] = '{1'b0, 4'b0011, 12'o0054, 32'h2800_0000, 4'b0001};
    tbl[20] = '{1'b0, 4'b0011, 12'o0054, 32'h2900_0000, 4'b0010};

    // Reset with requests pending: no grant may leak out.
    reset_n   = 1'b0;
    hold      = 1'b0;
    req_valid = 4'b1111;
    req_addr  = '0;
    req_data  = '0;
    @(posedge clk);
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].h, tbl[i].v, tbl[i].a, tbl[i].seed, tbl[i].rdy);
    end

    // Reset right after a transfer: state clears, pointer returns to 0.
    // Pointer is 2 here, so requester 0 wins via wrap and the pointer becomes 1.
    step(1'b0, 4'b0001, 12'o0003, 32'h3000_0000, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("ready_in_midreset", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_wr_valid", 32'(wr_valid), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    reset_n   = 1'b1;
    cnt_model = '0;
    last_id   = '0;
    last_data = '0;
    // Pointer back at 0: requester 0 wins, not 1.
    step(1'b0, 4'b1111, 12'o0000, 32'h3100_0000, 4'b0001);

    // Saturation of wr_count under continuous contention (1 write so far).
    hold      = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 65533; i++) @(posedge clk);
    #1;
    chk("count_FFFE", 32'(wr_count), 32'h0000_FFFE);
    @(posedge clk);
    #1;
    chk("count_FFFF", 32'(wr_count), 32'h0000_FFFF);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("count_saturated", 32'(wr_count), 32'h0000_FFFF);
    chk("still_writing", 32'(wr_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares one register bank write port among REQ independent requesters.
- Each requester presents a register address and a data word over a valid/ready handshake.
- The arbiter grants one requester per cycle in round-robin order. It then drives the bank's one-hot write-enable vector and shared data bus from a registered output stage.
- It sits directly in front of the NUM x BITS enable-gated register bank.

Parameters:
BITS, 32, data width of each register and of each requester's data.
NUM, 7, number of registers in the bank (width of wr_en).
REQ, 4, number of requesters (REQ >= 2).
ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  synchronous, active-low reset.
hold  in  1  when 1, no grant is issued this cycle.
req_valid  in  REQ  per-requester write request.
req_addr  in  REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
req_data  in  REQ*BITS  flattened data; requester i occupies bits [i*BITS +: BITS].
req_ready  out  REQ  one-hot (or zero) grant; combinational.
wr_en  out  NUM  one-hot write enable to the register bank; registered.
wr_data  out  BITS  write data to the register bank; registered.
wr_valid  out  1  registered strobe: an accepted write is being presented this cycle.
wr_err  out  1  registered strobe: the accepted write had addr >= NUM.
grant_id  out  $clog2(REQ)  index of the requester whose write is on the output stage.
wr_count  out  16  saturating count of accepted writes.

Behaviour:
- Reset:
  - reset_n is synchronous, active-low; clock is clk.
  - While reset_n=0 at a rising edge, the following are cleared: rr_ptr=0, wr_en=0, wr_data=0, wr_valid=0, wr_err=0, grant_id=0, wr_count=0.
  - req_ready is forced to 0 while reset_n=0.
- Arbitration (combinational):
  - Eligible set = req_valid when hold=0 and reset_n=1; otherwise empty.
  - Winner = the first eligible index found searching rr_ptr, rr_ptr+1, ... modulo REQ.
  - req_ready[winner]=1; all other bits are 0. If no requester is eligible, req_ready=0.
  - req_ready never depends on req_addr or req_data.
- Transfer: occurs for requester i when req_valid[i] and req_ready[i] are both 1 at a rising edge.
- Pointer update:
  - On a transfer by i, rr_ptr <= (i+1) mod REQ. Wrap-around: a grant to REQ-1 sets rr_ptr to 0.
  - With no transfer, rr_ptr holds its value.
- Output stage, cycle after a transfer by i with address a (latency 1):
  - wr_valid=1, grant_id=i, wr_data=req_data[i].
  - If a<NUM: wr_en=(1<<a) and wr_err=0.
  - If a>=NUM: wr_en=0 and wr_err=1. The write is still accepted and counted, and the pointer still advances.
- Cycle after no transfer: wr_en=0, wr_valid=0, wr_err=0. wr_data and grant_id hold their last values.
- Throughput: one write per cycle sustained. Back-to-back writes to the same address are allowed; each produces its own wr_en pulse.
- wr_count:
  - Increments by 1 per transfer, including error writes.
  - Saturates at 16'hFFFF, with no wrap.
- Simultaneous hold=1 and requests: no grant, pointer frozen. The output stage still retires the write accepted in the previous cycle.
- A requester may drop req_valid without having been granted; the arbiter keeps no per-request state.
- Reset mid-operation: a write accepted in the cycle before reset asserts is dropped. wr_en=0 on the first edge with reset_n=0, and no bank write occurs.
- Invariants:
  - $onehot0(req_ready) and $onehot0(wr_en) always hold.
  - wr_en != 0 implies wr_valid=1.
  - wr_err=1 implies wr_en=0.

Test Plan:
- Single requester: after reset, req_valid=4'b0100, addr=5, data=32'hDEADBEEF. Required: req_ready=4'b0100 the same cycle. Next cycle wr_en=7'b0100000, wr_data=DEADBEEF, grant_id=2, wr_valid=1. rr_ptr becomes 3 and wr_count=1.
- Full contention: req_valid=4'b1111 held for 8 cycles. Required: grants in the order 0,1,2,3,0,1,2,3, one per cycle, each appearing on wr_en one cycle later. wr_count=8.
- Wrap and skip: rr_ptr=3, req_valid=4'b1001. Required: grant 3 then 0. With req_valid=4'b0010 and rr_ptr=3, grant 1.
- Bad address: requester 1 writes addr=7 with NUM=7. Required next cycle: wr_en=0, wr_err=1, wr_valid=1, grant_id=1, wr_count incremented.
- Hold: hold=1 for 3 cycles with req_valid=4'b1111. Required: req_ready=0, rr_ptr unchanged, and wr_valid=0 after the first held cycle. On hold=0, the grant resumes at rr_ptr.
- Reset: reset_n=0 in the cycle after a transfer. Required: wr_en=0, wr_valid=0, wr_count=0 and rr_ptr=0. wr_count saturation check: preload via 65536 transfers, then confirm wr_count stays at 16'hFFFF.
